// File: rtl/tetris_title_renderer.sv
// -----------------------------------------------------------------------------
// tetris_title_renderer
//   Streaming renderer for the "TETRIS" title banner. Maps each incoming
//   DrawX/DrawY onto a built-in 10x10 block-letter font that is scaled up by
//   2**SCALE_LOG2. It produces a lit flag and a 12-bit colour for every pixel,
//   two clocks after that pixel is presented. Letter colours come from a
//   6-entry palette. A frame-driven step can rotate the colours through the
//   letters and make the whole banner blink.
//
// Ports
//   Clk          in   1   pixel clock
//   Reset        in   1   asynchronous, active-high reset
//   pix_valid    in   1   DrawX/DrawY lie inside the active video region
//   DrawX        in   10  current pixel column
//   DrawY        in   10  current pixel row
//   frame_start  in   1   one-cycle pulse per frame
//   anim_en      in   1   1 = frame counter advances on frame_start
//   mode         in   2   [0] colour rotation enable, [1] blink enable
//   title_on     out  1   pixel is a lit glyph cell
//   title_rgb    out  12  pixel colour, 12'h000 whenever title_on = 0
//
// Pipeline: there is no handshake. One pixel enters every clock, and the
// result for a pixel appears exactly two clocks after that pixel is presented.
// -----------------------------------------------------------------------------
module tetris_title_renderer #(
   parameter int ORIGIN_X        = 380,
   parameter int ORIGIN_Y        = 40,
   parameter int SCALE_LOG2      = 2,
   parameter int GLYPH_W         = 10,
   parameter int GLYPH_H         = 10,
   parameter int NUM_LETTERS     = 6,
   parameter int FRAMES_PER_STEP = 30
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pix_valid,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        frame_start,
   input  logic        anim_en,
   input  logic [1:0]  mode,
   output logic        title_on,
   output logic [11:0] title_rgb
);

   localparam int LW    = $clog2(NUM_LETTERS);
   localparam int CW    = $clog2(GLYPH_W);
   localparam int RW    = $clog2(GLYPH_H);
   localparam int FW    = $clog2(FRAMES_PER_STEP + 1);
   localparam int BOX_W = (NUM_LETTERS * GLYPH_W) << SCALE_LOG2;
   localparam int BOX_H = GLYPH_H << SCALE_LOG2;

   // ---------------------------------------------------------------------------
   // Font: the artwork is drawn for 10x10 glyphs. Every pair of rows is
   // identical, so each glyph is described by its row pair (row >> 1).
   // Column 0 is the MSB of each row.
   // ---------------------------------------------------------------------------
   function automatic logic [GLYPH_W-1:0] glyph_row(input logic [LW-1:0] l,
                                                    input logic [RW-1:0] r);
      logic [2:0] p;
      p = 3'(r >> 1);
      glyph_row = '0;
      case (l)
         3'd0, 3'd2: begin                         // T
            glyph_row = (p == 3'd0) ? 10'b1111111111 : 10'b0000110000;
         end
         3'd1: begin                               // E
            case (p)
               3'd0, 3'd4: glyph_row = 10'b1111111111;
               3'd2:       glyph_row = 10'b1111111100;
               default:    glyph_row = 10'b1100000000;
            endcase
         end
         3'd3: begin                               // R
            case (p)
               3'd0, 3'd2: glyph_row = 10'b1111111100;
               3'd3:       glyph_row = 10'b1100001100;
               default:    glyph_row = 10'b1100000011;
            endcase
         end
         3'd4: glyph_row = 10'b0000110000;         // I
         3'd5: begin                               // S
            case (p)
               3'd0:    glyph_row = 10'b0111111111;
               3'd1:    glyph_row = 10'b1100000000;
               3'd2:    glyph_row = 10'b0111111110;
               3'd3:    glyph_row = 10'b0000000011;
               default: glyph_row = 10'b1111111110;
            endcase
         end
         default: glyph_row = '0;
      endcase
   endfunction

   function automatic logic [11:0] palette(input logic [LW-1:0] idx);
      case (idx)
         3'd0:    palette = 12'hf00;
         3'd1:    palette = 12'hf70;
         3'd2:    palette = 12'hff0;
         3'd3:    palette = 12'h7f0;
         3'd4:    palette = 12'h0df;
         3'd5:    palette = 12'he5f;
         default: palette = 12'h000;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Stage 0 (combinational): geometry. The origin comparison is done on the
   // raw coordinates, so a left or top miss can never wrap into the box.
   // ---------------------------------------------------------------------------
   logic [9:0]    rx, ry, gx, gy;
   logic          in_box_c;
   logic [LW-1:0] letter_c;
   logic [CW-1:0] col_c;
   logic [RW-1:0] row_c;

   assign rx       = DrawX - 10'(ORIGIN_X);
   assign ry       = DrawY - 10'(ORIGIN_Y);
   assign gx       = rx >> SCALE_LOG2;
   assign gy       = ry >> SCALE_LOG2;
   assign in_box_c = pix_valid
                     && (DrawX >= 10'(ORIGIN_X)) && (DrawY >= 10'(ORIGIN_Y))
                     && (rx < 10'(BOX_W)) && (ry < 10'(BOX_H));
   assign row_c    = RW'(gy);

   // Letter and column are found by comparison against each glyph's left edge
   // instead of by a divider.
   always_comb begin
      letter_c = '0;
      col_c    = CW'(gx);
      for (int i = 1; i < NUM_LETTERS; i++) begin
         if (gx >= 10'(i * GLYPH_W)) begin
            letter_c = LW'(i);
            col_c    = CW'(gx - 10'(i * GLYPH_W));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1 register. Fields are zeroed outside the box so the ROM index
   // always stays in range.
   // ---------------------------------------------------------------------------
   logic          s1_in_box;
   logic [LW-1:0] s1_letter;
   logic [CW-1:0] s1_col;
   logic [RW-1:0] s1_row;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_in_box <= 1'b0;
         s1_letter <= '0;
         s1_col    <= '0;
         s1_row    <= '0;
      end else begin
         s1_in_box <= in_box_c;
         s1_letter <= in_box_c ? letter_c : '0;
         s1_col    <= in_box_c ? col_c    : '0;
         s1_row    <= in_box_c ? row_c    : '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Animation state
   // ---------------------------------------------------------------------------
   logic [FW-1:0] frame_cnt;
   logic [LW-1:0] color_off;
   logic          blink_ph;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frame_cnt <= '0;
         color_off <= '0;
         blink_ph  <= 1'b0;
      end else begin
         if (frame_start && anim_en) begin
            if (frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
               frame_cnt <= '0;
               if (mode[0])
                  color_off <= (color_off == LW'(NUM_LETTERS - 1)) ? '0 : color_off + 1'b1;
               if (mode[1])
                  blink_ph <= ~blink_ph;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
         // With blink disabled, the phase returns to "visible". This takes
         // priority over any toggle that fires on the same clock.
         if (!mode[1])
            blink_ph <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: ROM lookup, colour pick and blanking. The current mode is used
   // directly, so a mode change affects the very next pixel that leaves
   // stage 2.
   // ---------------------------------------------------------------------------
   logic [GLYPH_W-1:0] row_bits;
   logic               pix_bit;
   logic [LW:0]        csum;
   logic [LW-1:0]      cidx;
   logic               on_c;
   logic [11:0]        rgb_c;

   assign row_bits = glyph_row(s1_letter, s1_row);
   assign pix_bit  = row_bits[CW'(GLYPH_W - 1) - s1_col];
   assign csum     = {1'b0, s1_letter} + {1'b0, color_off};
   assign cidx     = (csum >= (LW+1)'(NUM_LETTERS)) ? LW'(csum - (LW+1)'(NUM_LETTERS))
                                                    : LW'(csum);
   assign on_c     = s1_in_box & pix_bit & ~(mode[1] & blink_ph);
   assign rgb_c    = on_c ? palette(cidx) : 12'h000;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         title_on  <= 1'b0;
         title_rgb <= 12'h000;
      end else begin
         title_on  <= on_c;
         title_rgb <= rgb_c;
      end
   end

endmodule

// File: tb/tb_tetris_title_renderer.sv
module tb_tetris_title_renderer;

   localparam int FPS = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        pix_valid;
   logic [9:0]  DrawX, DrawY;
   logic        frame_start;
   logic        anim_en;
   logic [1:0]  mode;
   logic        title_on;
   logic [11:0] title_rgb;

   tetris_title_renderer #(.FRAMES_PER_STEP(FPS)) dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .anim_en(anim_en), .mode(mode),
      .title_on(title_on), .title_rgb(title_rgb)
   );

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   // The font is drawn as text. '#' marks a lit cell.
   string font [60] = '{
      "##########", "##########", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", "....##....", "....##....",
      "##########", "##########", "##........", "##........", "########..",
      "########..", "##........", "##........", "##########", "##########",
      "##########", "##########", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", "....##....", "....##....",
      "########..", "########..", "##......##", "##......##", "########..",
      "########..", "##....##..", "##....##..", "##......##", "##......##",
      "....##....", "....##....", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", "....##....", "....##....",
      ".#########", ".#########", "##........", "##........", ".########.",
      ".########.", "........##", "........##", "#########.", "#########."
   };
   logic [11:0] pal [6] = '{12'hf00, 12'hf70, 12'hff0, 12'h7f0, 12'h0df, 12'he5f};

   int m_cnt, m_off, m_ph;

   function automatic logic [12:0] model_pix(int x, int y, bit v);
      int gx, l, c, r;
      if (!v || x < 380 || x >= 620 || y < 40 || y >= 80) return 13'h0;
      gx = (x - 380) / 4;
      l  = gx / 10;
      c  = gx % 10;
      r  = (y - 40) / 4;
      if (font[l*10 + r].getc(c) != 8'h23) return 13'h0;
      if (mode[1] && m_ph == 1) return 13'h0;
      return {1'b1, pal[(l + m_off) % 6]};
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [12:0] exp_q[$];

   task automatic check(string tag, logic [12:0] obs, logic [12:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed on=%0b rgb=%03h, expected on=%0b rgb=%03h",
                tag, obs[12], obs[11:0], exp[12], exp[11:0]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic check_pixel(string tag, int x, int y, bit v);
      @(negedge Clk);
      DrawX = 10'(x); DrawY = 10'(y); pix_valid = v;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      check(tag, {title_on, title_rgb}, model_pix(x, y, v));
   endtask

   task automatic pulse(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         frame_start = 1'b1;
         @(negedge Clk);
         frame_start = 1'b0;
         if (anim_en) begin
            if (m_cnt == FPS - 1) begin
               m_cnt = 0;
               if (mode[0]) m_off = (m_off + 1) % 6;
               if (mode[1]) m_ph = 1 - m_ph;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         if (!mode[1]) m_ph = 0;
      end
   endtask

   task automatic set_mode(logic [1:0] m);
      @(negedge Clk);
      mode = m;
      @(negedge Clk);
      if (!m[1]) m_ph = 0;
   endtask

   task automatic stream(int n);
      int x, y;
      bit v;
      for (int k = 0; k < n + 2; k++) begin
         @(negedge Clk);
         if (exp_q.size() == 2) check("stream", {title_on, title_rgb}, exp_q.pop_front());
         if (k < n) begin
            x = $urandom_range(370, 630);
            y = $urandom_range(30, 90);
            v = ($urandom_range(0, 7) != 0);
            DrawX = 10'(x); DrawY = 10'(y); pix_valid = v;
            exp_q.push_back(model_pix(x, y, v));
         end else begin
            pix_valid = 1'b0;
            exp_q.push_back(13'h0);
         end
      end
      exp_q.delete();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      Reset = 1'b1; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
      frame_start = 1'b0; anim_en = 1'b0; mode = 2'b00;
      m_cnt = 0; m_off = 0; m_ph = 0;
      #1;
      check("reset_state", {title_on, title_rgb}, 13'h0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      // Static colours
      check_pixel("t_row0_col0", 380, 40, 1'b1);
      check_pixel("t_stem_row2", 396, 48, 1'b1);
      check_pixel("t_off_row2",  380, 48, 1'b1);
      check_pixel("i_glyph",     560, 40, 1'b1);

      // Colour rotation
      set_mode(2'b01);
      anim_en = 1'b1;
      pulse(2);
      check_pixel("rot_one_step", 560, 40, 1'b1);
      pulse(10);
      check_pixel("rot_wrap", 560, 40, 1'b1);
      anim_en = 1'b0;
      pulse(4);
      check_pixel("anim_frozen", 560, 40, 1'b1);

      // Blink
      set_mode(2'b10);
      anim_en = 1'b1;
      pulse(2);
      check_pixel("blink_off_t", 380, 40, 1'b1);
      check_pixel("blink_off_i", 560, 40, 1'b1);
      pulse(2);
      check_pixel("blink_on", 380, 40, 1'b1);
      pulse(2);
      check_pixel("blink_off2", 396, 48, 1'b1);
      set_mode(2'b00);
      check_pixel("blink_mode_clear", 396, 48, 1'b1);

      // Edges
      check_pixel("edge_x379",   379, 40, 1'b1);
      check_pixel("edge_x620",   620, 40, 1'b1);
      check_pixel("edge_y80",    380, 80, 1'b1);
      check_pixel("edge_y39",    380, 39, 1'b1);
      check_pixel("edge_invalid",380, 40, 1'b0);
      check_pixel("edge_last_s", 619, 79, 1'b1);
      check_pixel("edge_t_foot", 399, 79, 1'b1);

      // Random bursts with random mode/animation settings
      for (int b = 0; b < 8; b++) begin
         set_mode(2'($urandom_range(0, 3)));
         anim_en = 1'($urandom_range(0, 1));
         pulse($urandom_range(0, 5));
         stream(40);
      end

      // Reset mid-rotation
      set_mode(2'b01);
      anim_en = 1'b1;
      for (int i = 0; i < 12 && m_off != 3; i++) pulse(1);
      check_pixel("pre_reset_rot3", 380, 40, 1'b1);
      #2;
      Reset = 1'b1;
      m_cnt = 0; m_off = 0; m_ph = 0;
      #1;
      check("reset_async", {title_on, title_rgb}, 13'h0);
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      check("reset_release_1clk", {title_on, title_rgb}, 13'h0);
      @(posedge Clk);
      #1;
      check("reset_release_2clk", {title_on, title_rgb}, model_pix(380, 40, 1'b1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
